// File: rtl/eth_idma_req_sched.sv
// Multi-channel request scheduler in front of an iDMA backend: per-channel request
// FIFOs, round-robin issue under an in-flight limit, in-order response retirement.
module eth_idma_req_sched #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned TFLenWidth  = 32,
    parameter int unsigned QueueDepth  = 4,
    parameter int unsigned MaxInFlight = 4,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumChannels-1:0]            ch_req_valid_i,
    output logic [NumChannels-1:0]            ch_req_ready_o,
    input  logic [NumChannels*AddrWidth-1:0]  ch_src_addr_i,
    input  logic [NumChannels*AddrWidth-1:0]  ch_dst_addr_i,
    input  logic [NumChannels*TFLenWidth-1:0] ch_len_i,
    output logic                              be_req_valid_o,
    input  logic                              be_req_ready_i,
    output logic [AddrWidth-1:0]              be_src_addr_o,
    output logic [AddrWidth-1:0]              be_dst_addr_o,
    output logic [TFLenWidth-1:0]             be_len_o,
    input  logic                              be_rsp_valid_i,
    output logic                              be_rsp_ready_o,
    input  logic                              be_rsp_error_i,
    output logic [NumChannels*CntWidth-1:0]   done_cnt_o,
    output logic [NumChannels-1:0]            irq_o,
    output logic [NumChannels-1:0]            err_o,
    input  logic [NumChannels-1:0]            irq_clr_i,
    output logic                              busy_o
);

    localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned QAW  = $clog2(QueueDepth);
    localparam int unsigned IdAW = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;
    localparam int unsigned IfW  = $clog2(MaxInFlight + 1);

    typedef struct packed {
        logic [AddrWidth-1:0]  src;
        logic [AddrWidth-1:0]  dst;
        logic [TFLenWidth-1:0] len;
    } req_t;

    typedef enum logic [0:0] {
        ST_ARB,
        ST_HOLD
    } state_e;

    req_t             r_fifo   [NumChannels][QueueDepth];
    logic [QAW:0]     r_wptr   [NumChannels];
    logic [QAW:0]     r_rptr   [NumChannels];
    logic [ChW-1:0]   r_idq    [MaxInFlight];
    logic [IdAW-1:0]  r_id_wp;
    logic [IdAW-1:0]  r_id_rp;
    logic [IfW-1:0]   r_inflight;
    logic [ChW-1:0]   r_prio;
    logic [ChW-1:0]   r_grant;
    state_e           r_state;
    logic [CntWidth-1:0] r_cnt [NumChannels];
    logic [NumChannels-1:0] r_irq;
    logic [NumChannels-1:0] r_err;

    state_e           w_state_nxt;
    logic [NumChannels-1:0] w_full;
    logic [NumChannels-1:0] w_empty;
    logic [NumChannels-1:0] w_acc;
    logic [NumChannels-1:0] w_zero;
    logic [NumChannels-1:0] w_push;
    logic [NumChannels-1:0] w_pop;
    logic [NumChannels-1:0] w_irq_set;
    logic [NumChannels-1:0] w_err_set;
    logic             w_rr_valid;
    logic [ChW-1:0]   w_rr_idx;
    logic             w_issue_ok;
    logic             w_valid;
    logic [ChW-1:0]   w_sel;
    logic             w_be_hs;
    logic             w_rsp_hs;
    logic [ChW-1:0]   w_rsp_id;
    req_t             w_head;

    function automatic logic [IdAW-1:0] id_inc(input logic [IdAW-1:0] p);
        if (32'(p) == MaxInFlight - 1) return '0;
        return p + 1'b1;
    endfunction

    // Zero-length requests are handshaken but only flag an error, never enqueued.
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_acc   = '0;
        w_zero  = '0;
        w_push  = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            w_empty[c] = (r_wptr[c] == r_rptr[c]);
            w_full[c]  = (r_wptr[c][QAW] != r_rptr[c][QAW]) &&
                         (r_wptr[c][QAW-1:0] == r_rptr[c][QAW-1:0]);
            w_acc[c]   = rst_ni && ch_req_valid_i[c] && !w_full[c];
            w_zero[c]  = w_acc[c] && (ch_len_i[c*TFLenWidth +: TFLenWidth] == '0);
            w_push[c]  = w_acc[c] && !w_zero[c];
        end
    end

    assign ch_req_ready_o = ~w_full | {NumChannels{~rst_ni}};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
                if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (w_push[c]) begin
                r_fifo[c][r_wptr[c][QAW-1:0]] <= '{
                    src: ch_src_addr_i[c*AddrWidth +: AddrWidth],
                    dst: ch_dst_addr_i[c*AddrWidth +: AddrWidth],
                    len: ch_len_i[c*TFLenWidth +: TFLenWidth]
                };
            end
        end
    end

    // Round-robin: first non-empty channel at or after the priority pointer.
    always_comb begin : p_arb
        int unsigned idx;
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            idx = 32'(r_prio) + i;
            if (idx >= NumChannels) idx = idx - NumChannels;
            if (!w_rr_valid && !w_empty[idx]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = ChW'(idx);
            end
        end
    end

    assign w_issue_ok = (r_inflight != IfW'(MaxInFlight));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_ARB;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:  if (w_issue_ok && w_rr_valid && !be_req_ready_i) w_state_nxt = ST_HOLD;
            ST_HOLD: if (be_req_ready_i) w_state_nxt = ST_ARB;
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_sel   = r_grant;
        case (r_state)
            ST_ARB: begin
                w_valid = w_issue_ok && w_rr_valid;
                w_sel   = w_rr_idx;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                w_sel   = r_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_grant <= '0;
            r_prio  <= '0;
        end else begin
            if (r_state == ST_ARB && w_valid && !be_req_ready_i) r_grant <= w_sel;
            if (w_be_hs) r_prio <= (32'(w_sel) == NumChannels - 1) ? '0 : w_sel + 1'b1;
        end
    end

    assign w_head         = r_fifo[w_sel][r_rptr[w_sel][QAW-1:0]];
    assign be_req_valid_o = rst_ni && w_valid;
    assign be_src_addr_o  = w_head.src;
    assign be_dst_addr_o  = w_head.dst;
    assign be_len_o       = w_head.len;
    assign w_be_hs        = be_req_valid_o && be_req_ready_i;

    always_comb begin
        w_pop = '0;
        if (w_be_hs) w_pop[w_sel] = 1'b1;
    end

    assign be_rsp_ready_o = rst_ni && (r_inflight != '0);
    assign w_rsp_hs       = be_rsp_valid_i && be_rsp_ready_o;
    assign w_rsp_id       = r_idq[r_id_rp];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id_wp    <= '0;
            r_id_rp    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_be_hs)  r_id_wp <= id_inc(r_id_wp);
            if (w_rsp_hs) r_id_rp <= id_inc(r_id_rp);
            case ({w_be_hs, w_rsp_hs})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_be_hs) r_idq[r_id_wp] <= w_sel;
    end

    always_comb begin
        w_irq_set = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            w_irq_set[c] = w_rsp_hs && (w_rsp_id == ChW'(c));
        end
        w_err_set = w_zero | (w_irq_set & {NumChannels{be_rsp_error_i}});
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_irq <= '0;
            r_err <= '0;
            for (int unsigned c = 0; c < NumChannels; c++) r_cnt[c] <= '0;
        end else begin
            r_irq <= w_irq_set | (r_irq & ~irq_clr_i);
            r_err <= w_err_set | (r_err & ~irq_clr_i);
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (w_irq_set[c]) r_cnt[c] <= r_cnt[c] + 1'b1;
            end
        end
    end

    always_comb begin
        done_cnt_o = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            done_cnt_o[c*CntWidth +: CntWidth] = r_cnt[c];
        end
    end

    assign irq_o  = r_irq;
    assign err_o  = r_err;
    assign busy_o = rst_ni && (!(&w_empty) || (r_inflight != '0));

endmodule

// File: tb/tb_eth_idma_req_sched.sv
// Directed bench for eth_idma_req_sched: vector table for single-transfer behaviour,
// hand sequences for arbitration, in-flight limit, stall, flag and wrap corners.
module tb_eth_idma_req_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  ch_req_valid_i;
    logic [1:0]  ch_req_ready_o;
    logic [63:0] ch_src_addr_i;
    logic [63:0] ch_dst_addr_i;
    logic [63:0] ch_len_i;
    logic        be_req_valid_o;
    logic        be_req_ready_i;
    logic [31:0] be_src_addr_o;
    logic [31:0] be_dst_addr_o;
    logic [31:0] be_len_o;
    logic        be_rsp_valid_i;
    logic        be_rsp_ready_o;
    logic        be_rsp_error_i;
    logic [7:0]  done_cnt_o;
    logic [1:0]  irq_o;
    logic [1:0]  err_o;
    logic [1:0]  irq_clr_i;
    logic        busy_o;

    eth_idma_req_sched #(.CntWidth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ch_req_valid_i(ch_req_valid_i), .ch_req_ready_o(ch_req_ready_o),
        .ch_src_addr_i(ch_src_addr_i), .ch_dst_addr_i(ch_dst_addr_i), .ch_len_i(ch_len_i),
        .be_req_valid_o(be_req_valid_o), .be_req_ready_i(be_req_ready_i),
        .be_src_addr_o(be_src_addr_o), .be_dst_addr_o(be_dst_addr_o), .be_len_o(be_len_o),
        .be_rsp_valid_i(be_rsp_valid_i), .be_rsp_ready_o(be_rsp_ready_o),
        .be_rsp_error_i(be_rsp_error_i), .done_cnt_o(done_cnt_o),
        .irq_o(irq_o), .err_o(err_o), .irq_clr_i(irq_clr_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic        rst_n;
        logic [1:0]  vld;
        logic [31:0] src0, dst0, len0, len1;
        logic        bready, rvld, rerr;
        logic [1:0]  clr;
        logic [1:0]  e_cready;
        logic        e_bvalid;
        logic [31:0] e_src, e_dst, e_len;
        logic        e_rready, e_busy;
        logic [1:0]  e_irq, e_err;
        logic [3:0]  e_cnt0, e_cnt1;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in;
        ch_req_valid_i = '0;
        ch_src_addr_i  = '0;
        ch_dst_addr_i  = '0;
        ch_len_i       = '0;
        be_req_ready_i = 1'b0;
        be_rsp_valid_i = 1'b0;
        be_rsp_error_i = 1'b0;
        irq_clr_i      = '0;
    endtask

    task automatic do_reset;
        clr_in();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic set_req(input int c, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] l);
        ch_req_valid_i[c]        = 1'b1;
        ch_src_addr_i[c*32 +: 32] = s;
        ch_dst_addr_i[c*32 +: 32] = d;
        ch_len_i[c*32 +: 32]      = l;
    endtask

    function automatic vec_t blank();
        vec_t r;
        r.rst_n = 1'b1;   r.vld = '0;      r.src0 = '0;     r.dst0 = '0;
        r.len0 = '0;      r.len1 = 32'd8;  r.bready = 1'b0; r.rvld = 1'b0;
        r.rerr = 1'b0;    r.clr = '0;      r.e_cready = 2'b11; r.e_bvalid = 1'b0;
        r.e_src = '0;     r.e_dst = '0;    r.e_len = '0;    r.e_rready = 1'b0;
        r.e_busy = 1'b0;  r.e_irq = '0;    r.e_err = '0;    r.e_cnt0 = '0;
        r.e_cnt1 = '0;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] grants [6];
        int n_g, n_hs, n_push, n_rsp;

        for (int i = 0; i < NV; i++) v[i] = blank();
        // reset with stimulus present; nothing may be accepted
        v[0].rst_n = 1'b0; v[0].vld = 2'b11; v[0].len0 = 32'd64; v[0].bready = 1'b1;
        // single ch0 transfer
        v[1].vld = 2'b01; v[1].src0 = 32'h1000; v[1].dst0 = 32'h2000; v[1].len0 = 32'd64;
        v[1].bready = 1'b1;
        v[2].bready = 1'b1; v[2].e_bvalid = 1'b1; v[2].e_busy = 1'b1;
        v[2].e_src = 32'h1000; v[2].e_dst = 32'h2000; v[2].e_len = 32'd64;
        v[3].bready = 1'b1; v[3].e_rready = 1'b1; v[3].e_busy = 1'b1;
        v[4].rvld = 1'b1; v[4].e_rready = 1'b1; v[4].e_busy = 1'b1;
        for (int i = 5; i < NV; i++) v[i].e_cnt0 = 4'd1;
        v[5].e_irq = 2'b01;
        v[6].clr = 2'b01; v[6].e_irq = 2'b01;
        // zero-length on ch1
        v[8].vld = 2'b10; v[8].len1 = '0;
        v[9].e_err = 2'b10;
        v[10].clr = 2'b10; v[10].e_err = 2'b10;
        v[12].vld = 2'b10; v[12].len1 = '0; v[12].clr = 2'b10;
        v[13].clr = 2'b10; v[13].e_err = 2'b10;

        do_reset();
        for (int i = 0; i < NV; i++) begin
            rst_ni         = v[i].rst_n;
            ch_req_valid_i = v[i].vld;
            ch_src_addr_i  = {32'h5000, v[i].src0};
            ch_dst_addr_i  = {32'h6000, v[i].dst0};
            ch_len_i       = {v[i].len1, v[i].len0};
            be_req_ready_i = v[i].bready;
            be_rsp_valid_i = v[i].rvld;
            be_rsp_error_i = v[i].rerr;
            irq_clr_i      = v[i].clr;
            #1;
            chk($sformatf("row%0d_cready", i), ch_req_ready_o, v[i].e_cready);
            chk($sformatf("row%0d_bvalid", i), be_req_valid_o, v[i].e_bvalid);
            if (v[i].e_bvalid) begin
                chk($sformatf("row%0d_src", i), be_src_addr_o, v[i].e_src);
                chk($sformatf("row%0d_dst", i), be_dst_addr_o, v[i].e_dst);
                chk($sformatf("row%0d_len", i), be_len_o, v[i].e_len);
            end
            chk($sformatf("row%0d_rready", i), be_rsp_ready_o, v[i].e_rready);
            chk($sformatf("row%0d_busy", i), busy_o, v[i].e_busy);
            chk($sformatf("row%0d_irq", i), irq_o, v[i].e_irq);
            chk($sformatf("row%0d_err", i), err_o, v[i].e_err);
            chk($sformatf("row%0d_cnt0", i), done_cnt_o[3:0], v[i].e_cnt0);
            chk($sformatf("row%0d_cnt1", i), done_cnt_o[7:4], v[i].e_cnt1);
            tick();
        end

        // round-robin grant order with both channels loaded
        do_reset();
        n_g = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            clr_in();
            if (cyc < 3) begin
                set_req(0, 32'hA000_0000 | cyc, 32'hB000_0000 | cyc, 32'd16);
                set_req(1, 32'hA001_0000 | cyc, 32'hB001_0000 | cyc, 32'd16);
            end
            be_req_ready_i = 1'b1;
            be_rsp_valid_i = 1'b1;
            #1;
            if (be_req_valid_o && be_req_ready_i) begin
                if (n_g < 6) grants[n_g] = be_src_addr_o;
                n_g++;
            end
            tick();
        end
        chk("rr_count", n_g, 6);
        for (int i = 0; i < 6 && i < n_g; i++)
            chk($sformatf("rr_grant%0d", i), grants[i],
                32'hA000_0000 | ((i % 2) << 16) | (i / 2));
        clr_in(); #1;
        chk("rr_busy", busy_o, 0);
        chk("rr_cnt0", done_cnt_o[3:0], 3);
        chk("rr_cnt1", done_cnt_o[7:4], 3);

        // in-flight limit and same-cycle issue/retire
        do_reset();
        n_hs = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            clr_in();
            if (cyc < 4) begin
                set_req(0, 32'hC000 + cyc, 32'hD000, 32'd4);
                set_req(1, 32'hC100 + cyc, 32'hD100, 32'd4);
            end
            be_req_ready_i = 1'b1;
            #1;
            if (be_req_valid_o && be_req_ready_i) n_hs++;
            tick();
        end
        chk("mif_hs", n_hs, 4);
        clr_in(); be_req_ready_i = 1'b1; be_rsp_valid_i = 1'b1; #1;
        chk("mif_blocked", be_req_valid_o, 0);
        chk("mif_rready", be_rsp_ready_o, 1);
        tick();
        chk("mif_resume", be_req_valid_o, 1);
        tick();
        be_rsp_valid_i = 1'b0; #1;
        chk("mif_same_cycle", be_req_valid_o, 1);
        tick();
        chk("mif_refull", be_req_valid_o, 0);
        chk("mif_busy", busy_o, 1);
        be_rsp_valid_i = 1'b1;
        for (int cyc = 0; cyc < 40 && busy_o; cyc++) tick();
        chk("mif_drained", busy_o, 0);
        chk("mif_cnt0", done_cnt_o[3:0], 4);
        chk("mif_cnt1", done_cnt_o[7:4], 4);

        // stalled backend: grant locked to ch0 although ch1 has priority
        do_reset();
        clr_in(); set_req(0, 32'h1111, 32'h2222, 32'd8); be_req_ready_i = 1'b1; tick();
        clr_in(); be_req_ready_i = 1'b1; tick();
        clr_in(); be_rsp_valid_i = 1'b1; tick();
        clr_in(); set_req(0, 32'h3000, 32'h4000, 32'h80); tick();
        for (int k = 0; k < 5; k++) begin
            clr_in();
            if (k == 0) set_req(1, 32'h5000, 32'h6000, 32'h20);
            #1;
            chk($sformatf("stall%0d_valid", k), be_req_valid_o, 1);
            chk($sformatf("stall%0d_src", k), be_src_addr_o, 32'h3000);
            chk($sformatf("stall%0d_dst", k), be_dst_addr_o, 32'h4000);
            chk($sformatf("stall%0d_len", k), be_len_o, 32'h80);
            tick();
        end
        clr_in(); be_req_ready_i = 1'b1; #1;
        chk("stall_release_src", be_src_addr_o, 32'h3000);
        tick();
        #1;
        chk("stall_next_valid", be_req_valid_o, 1);
        chk("stall_next_src", be_src_addr_o, 32'h5000);
        tick();

        // error response with simultaneous clear: set wins
        clr_in(); be_rsp_valid_i = 1'b1; be_rsp_error_i = 1'b1; irq_clr_i = 2'b01; #1;
        chk("errclr_rready", be_rsp_ready_o, 1);
        tick();
        clr_in(); #1;
        chk("errclr_irq0", irq_o[0], 1);
        chk("errclr_err0", err_o[0], 1);
        irq_clr_i = 2'b01; tick();
        clr_in(); #1;
        chk("clr_irq0", irq_o[0], 0);
        chk("clr_err0", err_o[0], 0);
        be_rsp_valid_i = 1'b1; tick();
        clr_in(); #1;
        chk("ch1_irq", irq_o, 2'b10);
        chk("ch1_err", err_o, 2'b00);
        chk("ch1_cnt", done_cnt_o, 8'h12);

        // 16 completions on ch0 wrap a 4-bit counter
        do_reset();
        n_push = 0;
        n_rsp  = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            clr_in();
            if (n_push < 16) set_req(0, 32'h7000 + n_push, 32'h8000, 32'd4);
            be_req_ready_i = 1'b1;
            be_rsp_valid_i = 1'b1;
            #1;
            if (ch_req_valid_i[0] && ch_req_ready_o[0]) n_push++;
            if (be_rsp_valid_i && be_rsp_ready_o) n_rsp++;
            tick();
            if (n_rsp == 16) break;
        end
        clr_in(); #1;
        chk("wrap_rsp", n_rsp, 16);
        chk("wrap_cnt0", done_cnt_o[3:0], 0);
        chk("wrap_irq0", irq_o[0], 1);
        chk("wrap_busy", busy_o, 0);

        // full FIFO: simultaneous enqueue and dequeue only dequeues; then reset mid-flight
        do_reset();
        for (int k = 0; k < 4; k++) begin
            clr_in(); set_req(0, 32'h9000 + k, 32'h9100, 32'd4); tick();
        end
        clr_in(); set_req(0, 32'h9999, 32'h9100, 32'd4); be_req_ready_i = 1'b1; #1;
        chk("full_ready", ch_req_ready_o, 2'b10);
        chk("full_src", be_src_addr_o, 32'h9000);
        tick();
        clr_in(); #1;
        chk("full_deq_only", ch_req_ready_o, 2'b11);
        chk("full_head", be_src_addr_o, 32'h9001);
        rst_ni = 1'b0; be_rsp_valid_i = 1'b1; tick();
        chk("rst_rready", be_rsp_ready_o, 0);
        chk("rst_valid", be_req_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cready", ch_req_ready_o, 2'b11);
        rst_ni = 1'b1; #1;
        chk("post_rst_rready", be_rsp_ready_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_cnt", done_cnt_o, 0);
        tick();
        clr_in();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
